// File: rtl/spi_slave.sv
// SPI mode-0 slave, one-entry tx buffer; abort pulse output only with SPI_SLAVE_FRAME_ERR_EN.
// Latency: rx_data updates ~3 clk after the last sclk rise (2-flop sync + edge detect), rx_valid one clk later.
// Backpressure: tx_ready low while the tx buffer is full; an empty buffer at word start sends DEFAULT_TX.
module spi_slave #(
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] DEFAULT_TX = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int                CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t             state_q, state_d;
    logic               cs_s1, cs_s2, cs_d;
    logic               sclk_s1, sclk_s2, sclk_d;
    logic               mosi_s1, mosi_s2;
    logic [1:0]         settle;
    logic               armed;
    logic               cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic [DATA_W-1:0]  tx_sr;
    logic [DATA_W-2:0]  rx_sr;
    logic [DATA_W-1:0]  rx_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  tx_buf;
    logic               tx_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_d    <= 1'b1;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            cs_s1   <= cs;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    // The synchronizer resets to cs=1, so a cs already low at reset release would look
    // like a fall; only accept falls after a genuinely sampled high has been seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle <= 2'd0;
            armed  <= 1'b0;
        end else begin
            if (settle != 2'd2)
                settle <= settle + 2'd1;
            if (settle == 2'd2 && cs_s2)
                armed <= 1'b1;
        end
    end

    assign cs_fall   = armed & cs_d & ~cs_s2;
    assign cs_rise   = ~cs_d & cs_s2;
    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign sclk_fall = ~sclk_s2 & sclk_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (bit_cnt == CNT_FULL) state_d = LOAD;
            default: state_d = IDLE;
        endcase
        if (cs_rise)
            state_d = IDLE;
    end

    assign rx_next = {rx_sr, mosi_s2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state_q)
                IDLE: bit_cnt <= '0;
                LOAD: begin
                    tx_sr   <= tx_full ? tx_buf : DEFAULT_TX;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    if (sclk_rise && bit_cnt != CNT_FULL) begin
                        rx_sr   <= rx_next[DATA_W-2:0];
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_LAST)
                            rx_data <= rx_next;
                    end else if (sclk_fall && bit_cnt != '0 && bit_cnt != CNT_FULL) begin
                        // the fall after the last rise belongs to the next word's LOAD
                        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                    end
                    if (bit_cnt == CNT_FULL)
                        rx_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // LOAD drains the buffer; a word offered in that same cycle refills it at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf  <= '0;
            tx_full <= 1'b0;
        end else if (state_q == LOAD && tx_full) begin
            if (tx_valid)
                tx_buf <= tx_data;
            else
                tx_full <= 1'b0;
        end else if (tx_valid && !tx_full) begin
            tx_buf  <= tx_data;
            tx_full <= 1'b1;
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_err <= 1'b0;
        else
            frame_err <= cs_rise && (state_q == SHIFT) && (bit_cnt != '0) && (bit_cnt != CNT_FULL);
    end
`endif

    assign miso     = (state_q != IDLE) & tx_sr[DATA_W-1];
    assign tx_ready = ~tx_full;
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 DATA_W, 8, frame word width in bits.
REQ-002 DEFAULT_TX, 8'hFF, word shifted out when no tx word is buffered (underrun).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sclk  input  1  SPI clock from master, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-006 cs  input  1  chip select from master, active-low, asynchronous.
REQ-007 mosi  input  1  serial data from master, MSB first.
REQ-008 miso  output  1  serial data to master, MSB first; 0 while cs high.
REQ-009 tx_data  input  DATA_W  next word to send.
REQ-010 tx_valid  input  1  tx_data valid; accepted when tx_valid && tx_ready.
REQ-011 tx_ready  output  1  one-entry tx buffer empty.
REQ-012 rx_data  output  DATA_W  last complete received word; held until next completion.
REQ-013 rx_valid  output  1  one-clk pulse per completed word.
REQ-014 busy  output  1  high from synced cs fall to synced cs rise.
REQ-015 frame_err  output  1  one-clk pulse on aborted word (present only with macro, REQ-034).

Function
REQ-016 sclk, cs, mosi each pass through a 2-flop synchronizer; edges detected from synced stage vs. one further register.
REQ-017 Operating constraint: sclk high and low phases each >= 4 clk periods; bench honours this.
REQ-018 FSM states IDLE, LOAD, SHIFT; IDLE->LOAD on synced cs fall; LOAD->SHIFT after one clk; SHIFT->LOAD after DATA_W sampled bits with cs still low; any state->IDLE on synced cs rise.
REQ-019 LOAD: tx shift register takes buffered word (buffer emptied, tx_ready rises next clk) or DEFAULT_TX if empty; miso drives bit DATA_W-1; bit counter cleared.
REQ-020 SHIFT: on detected sclk rise, synced mosi shifted into rx shift register LSB side; counter increments.
REQ-021 SHIFT: on detected sclk fall, tx shift register shifts left, miso drives next bit; no shift after the DATA_W-th rise (LOAD handles next word).
REQ-022 On the DATA_W-th sampled bit, rx_data takes the full word and rx_valid pulses on the following clk.
REQ-023 Back-to-back words within one cs-low frame supported without gap beyond REQ-017.
REQ-024 tx_valid accepted in the same cycle as LOAD empties buffer: LOAD uses old word, new word captured, tx_ready stays low.
REQ-025 tx_valid with tx_ready low ignored; buffer unchanged.
REQ-026 cs rise with counter in 1..DATA_W-1: partial word discarded, rx_data unchanged, no rx_valid; tx buffer contents retained.
REQ-027 cs rise with counter 0: no error, no rx_valid.
REQ-028 miso forced 0 in IDLE.
REQ-029 Counter width ceil(log2(DATA_W))+1; no wrap within a word.

Reset
REQ-030 rst_n low asynchronously: FSM IDLE, shift registers, counter, rx_data = 0; rx_valid, busy, miso, frame_err = 0; tx buffer empty, tx_ready = 1; synchronizers reset to cs=1, sclk=0, mosi=0.
REQ-031 Reset mid-frame aborts silently (no rx_valid, no frame_err); after release, slave waits for a fresh synced cs fall, ignoring a cs already low.
REQ-032 rx_valid, frame_err first assertable on the clk following rst_n release.

Configuration
REQ-033 Macro SPI_SLAVE_FRAME_ERR_EN controls abort reporting.
REQ-034 Defined: port frame_err exists and pulses one clk on REQ-026 condition. Undefined: port absent, aborts silently discarded; all other behaviour identical.

Verification
REQ-035 Preload tx 8'h3C, master sends 8'hA5 -> rx_data=8'hA5, one rx_valid pulse, master receives 8'h3C, tx_ready returns 1.
REQ-036 No tx preload, master sends 8'h12 -> master receives 8'hFF, rx_data=8'h12.
REQ-037 Two-word frame, tx 8'h11 then 8'h22 loaded during first word, master sends 8'hC3, 8'h5A -> master gets 8'h11, 8'h22; two rx_valid pulses with 8'hC3, 8'h5A.
REQ-038 cs raised after 4 bits -> no rx_valid, rx_data unchanged; with SPI_SLAVE_FRAME_ERR_EN one frame_err pulse.
REQ-039 rst_n pulsed low mid-word, cs held low -> all outputs at reset values, no activity until cs toggles high then low; next word 8'h96 received correctly.
REQ-040 tx_valid held high across LOAD with word 8'h7E -> 8'h7E sent in following word, no word lost or duplicated.
